// File: rtl/sine_taylor_ctrl.sv
// Taylor-series sin(x) sequencer that drives one shared Booth multiplier through a req/ack handshake.
// Q16 in, signed Q16 out; odd terms accumulate with alternating sign.
module sine_taylor_ctrl #(
    parameter int unsigned TERMS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [16:0] x,
    output logic        busy,
    output logic        done,
    output logic [17:0] result,
    output logic        mul_req,
    output logic [16:0] mul_a,
    output logic [16:0] mul_b,
    input  logic        mul_ack,
    input  logic [33:0] mul_p
);

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        TX,
        TC,
        DONE
    } state_t;

    state_t      state;
    logic [16:0] xr;
    logic [16:0] x2;
    logic [16:0] term;
    logic [2:0]  k;
    logic [18:0] acc;
    logic [16:0] prod;
    logic        unused_bits;

    // Q16 product: floor of a*b / 2^16, overflow bit dropped
    assign prod        = mul_p[32:16];
    assign unused_bits = ^{mul_p[33], mul_p[15:0], xr, term, acc[18]};

    function automatic logic [16:0] coef(input logic [2:0] idx);
        logic [16:0] c;
        case (idx)
            3'd1:    c = 17'd10923;
            3'd2:    c = 17'd3277;
            3'd3:    c = 17'd1560;
            3'd4:    c = 17'd910;
            3'd5:    c = 17'd596;
            3'd6:    c = 17'd420;
            3'd7:    c = 17'd312;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            xr      <= '0;
            x2      <= '0;
            term    <= '0;
            k       <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            mul_req <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    // the done pulse lands in IDLE; a start seen alongside it is dropped
                    if (start && !done) begin
                        xr      <= x;
                        term    <= x;
                        acc     <= {2'b00, x};
                        k       <= 3'd1;
                        busy    <= 1'b1;
                        mul_req <= 1'b1;
                        mul_a   <= x;
                        mul_b   <= x;
                        state   <= SQ;
                    end
                end
                SQ: begin
                    if (mul_ack) begin
                        x2    <= prod;
                        mul_a <= term;
                        mul_b <= prod;
                        state <= TX;
                    end
                end
                TX: begin
                    if (mul_ack) begin
                        term <= prod;
                        if (prod == '0) begin
                            mul_req <= 1'b0;
                            state   <= DONE;
                        end else begin
                            mul_a <= prod;
                            mul_b <= coef(k);
                            state <= TC;
                        end
                    end
                end
                TC: begin
                    if (mul_ack) begin
                        term <= prod;
                        if (k[0]) begin
                            acc <= acc - {2'b00, prod};
                        end else begin
                            acc <= acc + {2'b00, prod};
                        end
                        k <= k + 3'd1;
                        if (k == 3'(TERMS - 1) || prod == '0) begin
                            mul_req <= 1'b0;
                            state   <= DONE;
                        end else begin
                            mul_a <= prod;
                            mul_b <= x2;
                            state <= TX;
                        end
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    result <= acc[17:0];
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_taylor_ctrl.sv
// Randomised bench for sine_taylor_ctrl: a latency-configurable multiplier model plus a
// plain-arithmetic Taylor series reference.
module tb_sine_taylor_ctrl;

    localparam int unsigned TERMS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] x;
    logic        busy;
    logic        done;
    logic [17:0] result;
    logic        mul_req;
    logic [16:0] mul_a;
    logic [16:0] mul_b;
    logic        mul_ack;
    logic [33:0] mul_p;

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    int cnt;

    logic [33:0] obs_ops[$];
    logic [33:0] exp_ops[$];
    int          exp_res;
    int          exp_nmul;
    logic        prev_hold = 1'b0;
    logic [16:0] pa, pb;

    always #5 clk = ~clk;

    // multiplier: acknowledges lat cycles after each request begins
    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else if (!mul_req || mul_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end
    assign mul_ack = mul_req && (cnt == lat);
    assign mul_p   = {17'b0, mul_a} * {17'b0, mul_b};

    sine_taylor_ctrl #(.TERMS(TERMS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .mul_req (mul_req),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_ack (mul_ack),
        .mul_p   (mul_p)
    );

    always @(negedge clk) begin
        if (mul_req && mul_ack) obs_ops.push_back({mul_a, mul_b});
        if (prev_hold && mul_req) begin
            checks++;
            if (mul_a !== pa || mul_b !== pb) begin
                errors++;
                $display("FAIL operand_stable: got a=%0d b=%0d, required a=%0d b=%0d", mul_a, mul_b, pa, pb);
            end
        end
        prev_hold = mul_req && !mul_ack;
        pa        = mul_a;
        pb        = mul_b;
    end

    function automatic logic [16:0] fx(input logic [16:0] a, input logic [16:0] b);
        logic [33:0] p;
        p = {17'b0, a} * {17'b0, b};
        return p[32:16];
    endfunction

    // sin(x) = x - x^3/3! + x^5/5! - ..., each term from the previous one times x^2 then 1/((2k)(2k+1))
    task automatic model(input logic [16:0] xv);
        int          coef[8] = '{0, 10923, 3277, 1560, 910, 596, 420, 312};
        logic [16:0] sq, t, p;
        int          a;
        int          n;
        exp_ops.delete();
        exp_ops.push_back({xv, xv});
        sq = fx(xv, xv);
        t  = xv;
        a  = int'(xv);
        n  = 1;
        for (int kk = 1; kk < int'(TERMS); kk++) begin
            exp_ops.push_back({t, sq});
            p = fx(t, sq);
            n++;
            if (p == 0) break;
            exp_ops.push_back({p, 17'(coef[kk])});
            t = fx(p, 17'(coef[kk]));
            n++;
            if (kk % 2 == 1) a = a - int'(t);
            else a = a + int'(t);
            if (t == 0) break;
        end
        exp_res  = a;
        exp_nmul = n;
    endtask

    task automatic do_run(input logic [16:0] xv, input bit noise, output int dcyc,
                          output logic [17:0] res, output logic [17:0] res0,
                          output logic busy0, output logic busy_after);
        obs_ops.delete();
        @(negedge clk);
        start = 1'b1;
        x     = xv;
        @(posedge clk);
        #1 start = 1'b0;
        dcyc  = -1;
        res   = '0;
        res0  = '0;
        busy0 = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == 0) begin
                busy0 = busy;
                res0  = result;
            end
            if (done) begin
                dcyc = c;
                res  = result;
                break;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                x     = 17'($urandom);
            end
            @(posedge clk);
            #1;
        end
        if (noise) begin
            start = 1'b1;
            x     = 17'($urandom);
        end
        @(posedge clk);
        #1 start = 1'b0;
        busy_after = busy;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, result, mul_req, mul_a, mul_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%0d req=%b a=%0d b=%0d, required all 0",
                     busy, done, result, mul_req, mul_a, mul_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_unity;
        int dcyc; logic [17:0] res, res0; logic b0, ba; int bad;
        lat = 0;
        model(17'd65536);
        do_run(17'd65536, 1'b0, dcyc, res, res0, b0, ba);
        checks++;
        if (dcyc !== 2 * int'(TERMS) || dcyc !== exp_nmul + 1) begin
            errors++; $display("FAIL unity_latency: got cycle %0d, required %0d", dcyc, 2 * TERMS);
        end
        checks++;
        if (res !== 18'(exp_res) || (int'(res) - 55147) > 3 || (55147 - int'(res)) > 3) begin
            errors++; $display("FAIL unity_result: got %0d, required %0d (55147 +-3)", res, exp_res);
        end
        checks++;
        if (b0 !== 1'b1 || ba !== 1'b0) begin
            errors++; $display("FAIL unity_busy: got start=%b after=%b, required 1/0", b0, ba);
        end
        bad = (obs_ops.size() != exp_ops.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_ops[i]) if (obs_ops[i] !== exp_ops[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL unity_operands: got %0d ops (%0d differ), required %0d", obs_ops.size(), bad, exp_ops.size());
        end
    endtask

    task automatic test_x60000;
        int dcyc; logic [17:0] res, res0; logic b0, ba; int bad;
        lat = 0;
        model(17'd60000);
        do_run(17'd60000, 1'b0, dcyc, res, res0, b0, ba);
        checks++;
        if (res !== 18'(exp_res) || (int'(res) - 51962) > 4 || (51962 - int'(res)) > 4) begin
            errors++; $display("FAIL x60000_result: got %0d, required %0d (51962 +-4)", res, exp_res);
        end
        bad = (obs_ops.size() != exp_ops.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_ops[i]) if (obs_ops[i] !== exp_ops[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL x60000_operands: got %0d ops (%0d differ), required %0d", obs_ops.size(), bad, exp_ops.size());
        end
        checks++;
        if (dcyc !== 2 * int'(TERMS)) begin
            errors++; $display("FAIL x60000_latency: got cycle %0d, required %0d", dcyc, 2 * TERMS);
        end
    endtask

    task automatic test_zero;
        int dcyc; logic [17:0] res, res0; logic b0, ba;
        lat = 0;
        do_run(17'd0, 1'b0, dcyc, res, res0, b0, ba);
        checks++;
        if (dcyc !== 3) begin
            errors++; $display("FAIL zero_latency: got cycle %0d, required 3", dcyc);
        end
        checks++;
        if (res !== 18'd0) begin
            errors++; $display("FAIL zero_result: got %0d, required 0", res);
        end
        checks++;
        if (ba !== 1'b0) begin
            errors++; $display("FAIL zero_busy_fall: got busy=%b in cycle 4, required 0", ba);
        end
    endtask

    task automatic test_latency;
        int dcyc; logic [17:0] res, res0; logic b0, ba; int bad;
        lat = 3;
        model(17'd65536);
        do_run(17'd65536, 1'b1, dcyc, res, res0, b0, ba);
        checks++;
        if (dcyc !== exp_nmul * (lat + 1) + 1) begin
            errors++; $display("FAIL stall_latency: got cycle %0d, required %0d", dcyc, exp_nmul * (lat + 1) + 1);
        end
        checks++;
        if (res !== 18'(exp_res)) begin
            errors++; $display("FAIL stall_result: got %0d, required %0d", res, exp_res);
        end
        bad = (obs_ops.size() != exp_ops.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_ops[i]) if (obs_ops[i] !== exp_ops[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_operands: got %0d ops (%0d differ), required %0d", obs_ops.size(), bad, exp_ops.size());
        end
        checks++;
        if (ba !== 1'b0) begin
            errors++; $display("FAIL stall_done_start: got busy=%b after done-cycle start, required 0", ba);
        end
        lat = 0;
    endtask

    task automatic test_reset_mid;
        int dcyc; logic [17:0] res, res0; logic b0, ba; int seen;
        lat = 0;
        @(negedge clk);
        start = 1'b1;
        x     = 17'd65536;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, mul_req, mul_a, mul_b} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b result=%0d req=%b a=%0d b=%0d, required all 0",
                     busy, done, result, mul_req, mul_a, mul_b);
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midreset_nodone: got %0d done/busy cycles, required 0", seen);
        end
        model(17'd65536);
        do_run(17'd65536, 1'b0, dcyc, res, res0, b0, ba);
        checks++;
        if (res !== 18'(exp_res) || dcyc !== exp_nmul + 1) begin
            errors++; $display("FAIL midreset_rerun: got %0d at cycle %0d, required %0d at %0d", res, dcyc, exp_res, exp_nmul + 1);
        end
    endtask

    task automatic test_back_to_back;
        int dcyc; logic [17:0] res, res0, prev; logic b0, ba;
        lat = 0;
        model(17'd65536);
        do_run(17'd65536, 1'b1, dcyc, res, res0, b0, ba);
        prev = res;
        checks++;
        if (ba !== 1'b0) begin
            errors++; $display("FAIL b2b_ignore_done_start: got busy=%b, required 0", ba);
        end
        model(17'd32768);
        do_run(17'd32768, 1'b0, dcyc, res, res0, b0, ba);
        checks++;
        if (b0 !== 1'b1 || res0 !== prev) begin
            errors++; $display("FAIL b2b_accept_hold: got busy=%b result=%0d, required 1 and %0d", b0, res0, prev);
        end
        checks++;
        if (res !== 18'(exp_res) || (int'(res) - 31419) > 3 || (31419 - int'(res)) > 3) begin
            errors++; $display("FAIL b2b_half_result: got %0d, required %0d (31419 +-3)", res, exp_res);
        end
        checks++;
        if (dcyc !== exp_nmul + 1) begin
            errors++; $display("FAIL b2b_half_latency: got cycle %0d, required %0d", dcyc, exp_nmul + 1);
        end
    endtask

    task automatic test_random;
        int dcyc; logic [17:0] res, res0; logic b0, ba; logic [16:0] xv;
        for (int n = 0; n < 8; n++) begin
            xv  = 17'($urandom);
            lat = int'($urandom_range(0, 2));
            model(xv);
            do_run(xv, 1'($urandom_range(0, 1)), dcyc, res, res0, b0, ba);
            checks++;
            if (res !== 18'(exp_res) || dcyc !== exp_nmul * (lat + 1) + 1) begin
                errors++;
                $display("FAIL random_run x=%0d lat=%0d: got %0d at cycle %0d, required %0d at %0d",
                         xv, lat, res, dcyc, 18'(exp_res), exp_nmul * (lat + 1) + 1);
            end
        end
        lat = 0;
    endtask

    initial begin
        test_reset;
        test_unity;
        test_x60000;
        test_zero;
        test_latency;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
